// File: rtl/rgb_pkg.sv
// rgb_pkg: shared types and constants for the RGB sequencer.
//   mode_e  - command mode encodings carried on cmd_mode
//   state_e - sequencer FSM states
//   rgb_t   - packed {R,G,B} colour, 8 bits per channel
package rgb_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_WHEEL   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_SOLID,
        ST_BR_UP,
        ST_BR_DN,
        ST_WHEEL,
        ST_FADE
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int WHEEL_MAX = 765;  // wheel positions 0..WHEEL_MAX-1
    localparam int LEVEL_MAX = 255;  // brightness level full scale

endpackage

// File: rtl/rgb_seq_ctrl_if.sv
// rgb_seq_ctrl_if: mode command channel (valid/ready handshake).
//   cmd_valid - master presents a command
//   cmd_ready - slave can accept this cycle
//   cmd_mode  - requested mode (rgb_pkg::mode_e encoding)
//   cmd_color - base colour {R,G,B} for SOLID / BREATHE
interface rgb_seq_ctrl_if;
    import rgb_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    rgb_t       cmd_color;

    modport master (output cmd_valid, cmd_mode, cmd_color, input cmd_ready);
    modport slave  (input cmd_valid, cmd_mode, cmd_color, output cmd_ready);
endinterface

// File: rtl/rgb_seq_ctrl_tick_gen.sv
// tick_gen: free-running prescaler, one-cycle tick every TICK_DIV clocks.
//   clk  - system clock
//   rst  - asynchronous active-high reset (count back to 0)
//   tick - high for one cycle when the count reaches TICK_DIV-1
module tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam logic [23:0] CNT_LAST = 24'(TICK_DIV - 1);

    logic [23:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? 24'd0 : cnt_q + 24'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 24'd0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/rgb_seq_ctrl.sv
// rgb_seq_ctrl: LED effect sequencer producing three PWM duty values.
//   clk, rst         - clock, asynchronous active-high reset
//   cmd (slave)      - mode command handshake, see rgb_seq_ctrl_if
//   duty_r/g/b       - registered 8-bit duty values
//   busy             - high while fading out before a mode change
// Modes: OFF, SOLID colour, BREATHE (level ramps 0..255..0), WHEEL (hue
// cycle). Leaving any non-OFF mode fades the current output to black first.
module rgb_seq_ctrl
    import rgb_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst,
    rgb_seq_ctrl_if.slave      cmd,
    output logic [7:0]         duty_r,
    output logic [7:0]         duty_g,
    output logic [7:0]         duty_b,
    output logic               busy
);
    localparam logic [9:0] POS_LAST = 10'(WHEEL_MAX - 1);
    localparam logic [7:0] LVL_TOP  = 8'(LEVEL_MAX);

    state_e     state_q, state_d;
    logic [7:0] level_q, level_d;
    logic [9:0] pos_q, pos_d;
    rgb_t       color_q, color_d;
    mode_e      tgt_mode_q, tgt_mode_d;
    rgb_t       tgt_color_q, tgt_color_d;
    rgb_t       fade_base_q, fade_base_d;
    rgb_t       duty_q, duty_d;

    logic  tick;
    logic  accept;
    logic  do_enter;
    mode_e ent_mode;
    rgb_t  ent_color;
    rgb_t  base;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    function automatic rgb_t wheel_rgb(input logic [9:0] p);
        rgb_t c;
        c = '0;
        if (p < 10'd255) begin
            c.r = 8'(10'd255 - p);
            c.b = p[7:0];
        end else if (p < 10'd510) begin
            c.g = 8'(p - 10'd255);
            c.b = 8'(10'd510 - p);
        end else begin
            c.r = 8'(p - 10'd510);
            c.g = 8'(10'd765 - p);
        end
        return c;
    endfunction

    // (base*(level+1))>>8: level 255 passes base through, level 0 gives 0.
    function automatic logic [7:0] scale(input logic [7:0] b, input logic [7:0] lvl);
        logic [15:0] prod;
        prod = {8'd0, b} * ({8'd0, lvl} + 16'd1);
        return prod[15:8];
    endfunction

    assign cmd.cmd_ready = (state_q != ST_FADE);
    assign busy          = (state_q == ST_FADE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        pos_d       = pos_q;
        color_d     = color_q;
        tgt_mode_d  = tgt_mode_q;
        tgt_color_d = tgt_color_q;
        fade_base_d = fade_base_q;
        do_enter    = 1'b0;
        ent_mode    = MODE_OFF;
        ent_color   = '0;

        // FADE keeps dimming whatever was on screen when it started.
        if (state_q == ST_FADE)       base = fade_base_q;
        else if (state_q == ST_WHEEL) base = wheel_rgb(pos_q);
        else                          base = color_q;

        // A command outranks a coincident tick.
        if (accept) begin
            if (state_q == ST_OFF) begin
                do_enter  = 1'b1;
                ent_mode  = mode_e'(cmd.cmd_mode);
                ent_color = cmd.cmd_color;
            end else begin
                state_d     = ST_FADE;
                tgt_mode_d  = mode_e'(cmd.cmd_mode);
                tgt_color_d = cmd.cmd_color;
                fade_base_d = base;
            end
        end else if (tick) begin
            case (state_q)
                ST_BR_UP: begin
                    level_d = level_q + 8'd1;
                    if (level_q == LVL_TOP - 8'd1) state_d = ST_BR_DN;
                end
                ST_BR_DN: begin
                    level_d = level_q - 8'd1;
                    if (level_q == 8'd1) state_d = ST_BR_UP;
                end
                ST_WHEEL: pos_d = (pos_q == POS_LAST) ? 10'd0 : pos_q + 10'd1;
                ST_FADE: begin
                    if (level_q == 8'd0) begin
                        do_enter  = 1'b1;
                        ent_mode  = tgt_mode_q;
                        ent_color = tgt_color_q;
                    end else begin
                        level_d = level_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end

        // Every mode entry restarts its effect from the beginning.
        if (do_enter) begin
            color_d = ent_color;
            pos_d   = 10'd0;
            case (ent_mode)
                MODE_SOLID:   begin state_d = ST_SOLID; level_d = LVL_TOP; end
                MODE_BREATHE: begin state_d = ST_BR_UP; level_d = 8'd0;    end
                MODE_WHEEL:   begin state_d = ST_WHEEL; level_d = LVL_TOP; end
                default:      begin state_d = ST_OFF;   level_d = 8'd0;    end
            endcase
        end

        if (state_q == ST_OFF) begin
            duty_d = '0;
        end else begin
            duty_d.r = scale(base.r, level_q);
            duty_d.g = scale(base.g, level_q);
            duty_d.b = scale(base.b, level_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_OFF;
            level_q     <= 8'd0;
            pos_q       <= 10'd0;
            color_q     <= '0;
            tgt_mode_q  <= MODE_OFF;
            tgt_color_q <= '0;
            fade_base_q <= '0;
            duty_q      <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            pos_q       <= pos_d;
            color_q     <= color_d;
            tgt_mode_q  <= tgt_mode_d;
            tgt_color_q <= tgt_color_d;
            fade_base_q <= fade_base_d;
            duty_q      <= duty_d;
        end
    end

    assign duty_r = duty_q.r;
    assign duty_g = duty_q.g;
    assign duty_b = duty_q.b;
endmodule

// File: tb/tb_rgb_seq_ctrl.sv
// Bench for rgb_seq_ctrl (TICK_DIV=4): directed effect checks plus random
// commands, all compared against a mode-level behavioural model every cycle.
module tb_rgb_seq_ctrl;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rgb_seq_ctrl_if ifc ();
    logic [7:0] duty_r, duty_g, duty_b;
    logic       busy;

    rgb_seq_ctrl #(.TICK_DIV(TD)) dut (
        .clk    (clk),
        .rst    (rst),
        .cmd    (ifc),
        .duty_r (duty_r),
        .duty_g (duty_g),
        .duty_b (duty_b),
        .busy   (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 off, 1 solid, 2 breathe, 3 wheel; fading is an overlay flag.
    int          m_mode, m_level, m_pos, m_up, m_fading, m_edges, m_tmode;
    logic [23:0] m_color, m_fbase, m_tcolor, m_duty;

    function automatic logic [23:0] wheel_ref(input int p);
        int r, g, b;
        if (p < 255)      begin r = 255 - p; g = 0;       b = p;       end
        else if (p < 510) begin r = 0;       g = p - 255; b = 510 - p; end
        else              begin r = p - 510; g = 765 - p; b = 0;       end
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    function automatic logic [7:0] sc(input logic [7:0] c, input int lvl);
        int v;
        v = (int'(c) * (lvl + 1)) / 256;
        return 8'(v);
    endfunction

    task automatic model_enter(input int md, input logic [23:0] c);
        m_mode   = md;
        m_color  = c;
        m_level  = (md == 1 || md == 3) ? 255 : 0;
        m_pos    = 0;
        m_up     = 1;
        m_fading = 0;
    endtask

    task automatic model_reset();
        model_enter(0, 24'h0);
        m_edges = 0; m_duty = 24'h0; m_fbase = 24'h0; m_tcolor = 24'h0; m_tmode = 0;
    endtask

    task automatic model_step();
        logic [23:0] b;
        bit tick;
        tick = (m_edges % TD) == TD - 1;
        m_edges++;
        b = m_fading ? m_fbase : (m_mode == 3 ? wheel_ref(m_pos) : m_color);
        m_duty = (!m_fading && m_mode == 0) ? 24'h0 :
                 {sc(b[23:16], m_level), sc(b[15:8], m_level), sc(b[7:0], m_level)};
        if (ifc.cmd_valid && !m_fading) begin
            if (m_mode == 0) model_enter(int'(ifc.cmd_mode), ifc.cmd_color);
            else begin
                m_fading = 1; m_fbase = b; m_tmode = int'(ifc.cmd_mode); m_tcolor = ifc.cmd_color;
            end
        end else if (tick) begin
            if (m_fading) begin
                if (m_level == 0) model_enter(m_tmode, m_tcolor);
                else m_level--;
            end else if (m_mode == 2) begin
                if (m_up) begin m_level++; if (m_level == 255) m_up = 0; end
                else      begin m_level--; if (m_level == 0)   m_up = 1; end
            end else if (m_mode == 3) begin
                m_pos = (m_pos + 1) % 765;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Per-cycle scoreboard, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("duty",  {duty_r, duty_g, duty_b}, m_duty);
            chk("busy",  busy, 32'(m_fading != 0));
            chk("ready", ifc.cmd_ready, 32'(m_fading == 0));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [1:0] m, input logic [23:0] c, output int waited);
        waited = 0;
        @(negedge clk);
        ifc.cmd_valid = 1'b1; ifc.cmd_mode = m; ifc.cmd_color = c;
        while (!ifc.cmd_ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (!ifc.cmd_ready) chk("send_timeout", ifc.cmd_ready, 1);
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int w;
    logic [23:0] cur, prev;
    int max_r, min_after, gb_or, seen_blue, seen_end, after_end;

    initial begin
        ifc.cmd_valid = 1'b0; ifc.cmd_mode = 2'd0; ifc.cmd_color = '0;
        #1 rst = 1'b1;
        idle(3);
        chk("rst_duty", {duty_r, duty_g, duty_b}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ifc.cmd_ready, 1);
        rst = 1'b0;

        // SOLID from OFF: duties follow two clocks after the command edge
        send(2'd1, 24'h8040FF, w);
        @(negedge clk);
        chk("solid_duty", {duty_r, duty_g, duty_b}, 32'h8040FF);
        chk("solid_busy", busy, 0);

        // BREATHE red, entered from OFF
        send(2'd0, 24'h0, w);
        send(2'd2, 24'hFF0000, w);
        max_r = 0; min_after = 255; gb_or = 0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (duty_r > max_r) max_r = duty_r;
            if (max_r == 255 && duty_r < min_after) min_after = duty_r;
            gb_or |= duty_g | duty_b;
        end
        chk("br_peak", max_r, 255);
        chk("br_trough", min_after, 0);
        chk("br_gb", gb_or, 0);

        // WHEEL from OFF
        send(2'd0, 24'h0, w);
        send(2'd3, 24'h0, w);
        @(negedge clk);
        chk("wheel_p0", {duty_r, duty_g, duty_b}, 32'hFF0000);
        seen_blue = 0; seen_end = 0; after_end = -1;
        prev = {duty_r, duty_g, duty_b};
        for (int i = 0; i < 3200; i++) begin
            @(negedge clk);
            cur = {duty_r, duty_g, duty_b};
            if (cur == 24'h0000FF) seen_blue = 1;
            if (seen_end && after_end < 0 && cur != prev) after_end = int'(cur);
            if (cur == 24'hFE0100) seen_end = 1;
            prev = cur;
        end
        chk("wheel_p255", seen_blue, 1);
        chk("wheel_p764", seen_end, 1);
        chk("wheel_wrap", after_end, 32'hFF0000);

        // SOLID white, then OFF with a command held during the fade
        send(2'd0, 24'h0, w);
        send(2'd1, 24'hFFFFFF, w);
        idle(2);
        chk("white", {duty_r, duty_g, duty_b}, 32'hFFFFFF);
        send(2'd0, 24'h0, w);
        chk("fade_busy", busy, 1);
        chk("fade_ready", ifc.cmd_ready, 0);
        send(2'd1, 24'h123456, w);
        chk("fade_len_ok", (w >= 255 * TD + 1 && w <= 256 * TD), 1);
        @(negedge clk);
        chk("held_cmd", {duty_r, duty_g, duty_b}, 32'h123456);

        // reset mid-FADE discards the WHEEL target
        send(2'd3, 24'h0, w);
        idle(100);
        chk("mid_fade_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_duty", {duty_r, duty_g, duty_b}, 0);
        chk("async_busy", busy, 0);
        chk("async_ready", ifc.cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        idle(300 * TD);
        chk("post_rst_duty", {duty_r, duty_g, duty_b}, 0);
        chk("post_rst_busy", busy, 0);

        // random commands, gaps long and short so some land mid-effect/fade
        for (int i = 0; i < 20; i++) begin
            send(2'($urandom_range(0, 3)), 24'($urandom), w);
            idle($urandom_range(0, 1200));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
